adder_bist: RTL and testbench
=============================

# adder_bist

Built-in self-test driver for the team's 32-bit combinational increment-adder (c = a + b + 1). It sits directly upstream of the adder: it generates operand pairs, drives them into the adder's a/b inputs, samples the returned c, and checks it against an internally computed expectation. It reports pass/fail, an error count and the first failing vector, replacing the ad-hoc testbench check with a synthesizable, repeatable sequence.

## Interface
- WIDTH, 32, operand/result width
- NUM_VECTORS, 256, number of pseudo-random vectors after the corner set (1..65535)
- SEED_A, 32'h1, LFSR seed for operand a (0 is replaced by 1)
- SEED_B, 32'hACE1, LFSR seed for operand b (0 is replaced by 1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle run request
- op_a  out  WIDTH  operand to adder input a
- op_b  out  WIDTH  operand to adder input b
- c  in  WIDTH  result from adder output c
- busy  out  1  run in progress
- done  out  1  run complete, held until next start
- pass  out  1  valid when done: error count is zero
- err_count  out  16  mismatches this run, saturates at 16'hFFFF
- vec_count  out  16  vectors checked this run
- fail_a, fail_b, fail_c  out  WIDTH each  operands and observed result of first mismatch

## Operation
- States: IDLE, CORNER, RANDOM, DONE.
- IDLE: busy=0, done=0, op_a=op_b=0. start=1 -> CORNER; clears counters and fail_*, loads LFSRs with seeds, loads corner vector 0.
- Corner vectors (a, b -> expected): (0,0 -> 1); (FFFFFFFF,0 -> 0, wrap); (FFFFFFFF,FFFFFFFF -> FFFFFFFF); (7FFFFFFF,0 -> 80000000).
- Each cycle in CORNER/RANDOM one vector is held on op_a/op_b; at the next edge c is compared to (op_a + op_b + 1) mod 2^WIDTH, vec_count increments, err_count increments (saturating) on mismatch, fail_* captured on the first mismatch only, and the next vector loads.
- After corner 3 is checked -> RANDOM; op_a/op_b = current LFSR states; both LFSRs advance once per vector.
- LFSR: 32-bit Galois, shift right, if bit0 was 1 XOR with 32'h80200003.
- After the NUM_VECTORS-th random vector is checked -> DONE: busy=0, done=1, op_a=op_b=0, pass=(err_count==0).
- DONE: start=1 -> restart exactly as from IDLE (counters cleared same edge).
- start while busy: ignored.

## Timing
- Reset values: state IDLE, op_a=op_b=0, busy=0, done=0, pass=0, err_count=0, vec_count=0, fail_*=0.
- Reset mid-run: immediate return to IDLE values; no partial result retained.
- c is combinational from op_a/op_b; one full cycle from operand change to sampling edge.
- Start sampled at edge E0; busy=1 after E0; checks occur at edges E1..E(4+NUM_VECTORS); done=1 after E(4+NUM_VECTORS). Default: done 260 cycles after start edge.
- pass, err_count, fail_* are stable from the done edge until the next start or reset.

## Structure
- Package adder_bist_pkg: state enum, four corner-vector constants, LFSR polynomial constant, counter width (16).
- Sub-module bist_lfsr (seed load, advance enable, state out), instantiated twice for a and b.
- Expected-value adder and comparator inline in the top.

## Test plan
- Correct adder model connected, start pulse -> done after 260 cycles, pass=1, err_count=0, vec_count=260.
- Faulty model c=a+b (no +1) -> err_count=260, pass=0, fail_a=0, fail_b=0, fail_c=0.
- Model forcing c=0 only when a=FFFFFFFF and b=FFFFFFFF -> err_count=1, fail_c=0, fail_a=fail_b=FFFFFFFF; corner 1 (expected 0) not flagged.
- rst_n low for 1 cycle at cycle 100 of a run -> all outputs at reset values; new start gives a full clean 260-vector run.
- start held high for 10 cycles during run -> identical result and timing to single pulse; start in DONE -> counters clear, identical repeated sequence (same fail_* for the faulty model).

Source files
------------

// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the increment-adder self-test driver.
package adder_bist_pkg;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned LFSR_W = 32;
    localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CORNER,
        ST_RANDOM,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    // Corner operands: zero, wrap to zero, all-ones sum, signed overflow.
    localparam vec_t CORNER_0 = '{a: 32'h0000_0000, b: 32'h0000_0000};
    localparam vec_t CORNER_1 = '{a: 32'hFFFF_FFFF, b: 32'h0000_0000};
    localparam vec_t CORNER_2 = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF};
    localparam vec_t CORNER_3 = '{a: 32'h7FFF_FFFF, b: 32'h0000_0000};

    function automatic vec_t corner_vec(input logic [1:0] idx);
        case (idx)
            2'd0:    return CORNER_0;
            2'd1:    return CORNER_1;
            2'd2:    return CORNER_2;
            default: return CORNER_3;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/adder_bist_lfsr.sv
// 32-bit right-shifting Galois LFSR with seed load and advance enable.
module bist_lfsr
    import adder_bist_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 32'h1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);

    // An all-zero seed would lock the register, so substitute 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

    // Load has priority over advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED_EFF;
        end else if (load) begin
            state <= SEED_EFF;
        end else if (advance) begin
            state <= {1'b0, state[LFSR_W-1:1]} ^ (state[0] ? LFSR_POLY : '0);
        end
    end

endmodule

// File: rtl/adder_bist.sv
// Self-test driver for the c = a + b + 1 adder: corner set then LFSR vectors.
module adder_bist
    import adder_bist_pkg::*;
#(
    parameter int unsigned       WIDTH       = 32,
    parameter int unsigned       NUM_VECTORS = 256,
    parameter logic [LFSR_W-1:0] SEED_A      = 32'h1,
    parameter logic [LFSR_W-1:0] SEED_B      = 32'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] vec_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [WIDTH-1:0] fail_c
);

    localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NUM_VECTORS - 1);

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  op_a_nxt, op_b_nxt, fail_a_nxt, fail_b_nxt, fail_c_nxt;
    logic              busy_nxt, done_nxt, pass_nxt;
    logic [CNT_W-1:0]  err_nxt, vec_nxt, rnd_cnt, rnd_nxt;
    logic              lfsr_load, lfsr_adv;
    logic [LFSR_W-1:0] lfsr_a, lfsr_b;
    logic [WIDTH-1:0]  expected;
    logic              mismatch;
    vec_t              cv;

    bist_lfsr #(.SEED(SEED_A)) u_lfsr_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .state   (lfsr_a)
    );

    bist_lfsr #(.SEED(SEED_B)) u_lfsr_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .state   (lfsr_b)
    );

    // Reference result for the vector currently held on the adder inputs.
    assign expected = op_a + op_b + WIDTH'(1);
    assign mismatch = (c != expected);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_a      <= '0;
            op_b      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            vec_count <= '0;
            rnd_cnt   <= '0;
            fail_a    <= '0;
            fail_b    <= '0;
            fail_c    <= '0;
        end else begin
            state     <= state_nxt;
            op_a      <= op_a_nxt;
            op_b      <= op_b_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            pass      <= pass_nxt;
            err_count <= err_nxt;
            vec_count <= vec_nxt;
            rnd_cnt   <= rnd_nxt;
            fail_a    <= fail_a_nxt;
            fail_b    <= fail_b_nxt;
            fail_c    <= fail_c_nxt;
        end
    end

    // Next state: check the held vector, then load the following one.
    always_comb begin
        state_nxt  = state;
        op_a_nxt   = op_a;
        op_b_nxt   = op_b;
        busy_nxt   = busy;
        done_nxt   = done;
        pass_nxt   = pass;
        err_nxt    = err_count;
        vec_nxt    = vec_count;
        rnd_nxt    = rnd_cnt;
        fail_a_nxt = fail_a;
        fail_b_nxt = fail_b;
        fail_c_nxt = fail_c;
        lfsr_load  = 1'b0;
        lfsr_adv   = 1'b0;
        cv         = corner_vec(vec_count[1:0] + 2'd1);

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_nxt  = ST_CORNER;
                    op_a_nxt   = WIDTH'(CORNER_0.a);
                    op_b_nxt   = WIDTH'(CORNER_0.b);
                    busy_nxt   = 1'b1;
                    done_nxt   = 1'b0;
                    pass_nxt   = 1'b0;
                    err_nxt    = '0;
                    vec_nxt    = '0;
                    rnd_nxt    = '0;
                    fail_a_nxt = '0;
                    fail_b_nxt = '0;
                    fail_c_nxt = '0;
                    lfsr_load  = 1'b1;
                end
            end
            ST_CORNER, ST_RANDOM: begin
                vec_nxt = sat_inc(vec_count);
                if (mismatch) begin
                    err_nxt = sat_inc(err_count);
                    if (err_count == '0) begin
                        fail_a_nxt = op_a;
                        fail_b_nxt = op_b;
                        fail_c_nxt = c;
                    end
                end
                if (state == ST_CORNER) begin
                    if (vec_count[1:0] == 2'd3) begin
                        state_nxt = ST_RANDOM;
                        op_a_nxt  = WIDTH'(lfsr_a);
                        op_b_nxt  = WIDTH'(lfsr_b);
                        lfsr_adv  = 1'b1;
                    end else begin
                        op_a_nxt = WIDTH'(cv.a);
                        op_b_nxt = WIDTH'(cv.b);
                    end
                end else if (rnd_cnt == LAST_RND) begin
                    state_nxt = ST_DONE;
                    op_a_nxt  = '0;
                    op_b_nxt  = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    pass_nxt  = (err_nxt == '0);
                end else begin
                    rnd_nxt  = rnd_cnt + CNT_W'(1);
                    op_a_nxt = WIDTH'(lfsr_a);
                    op_b_nxt = WIDTH'(lfsr_b);
                    lfsr_adv = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_adder_bist.sv
// Bench for adder_bist: fault-injectable adder model plus vector-list reference.
module tb_adder_bist;

    localparam int          NV    = 256;
    localparam int          TOTAL = NV + 4;
    localparam logic [31:0] SA    = 32'h1;
    localparam logic [31:0] SB    = 32'hACE1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a, op_b, c, fail_a, fail_b, fail_c;
    logic        busy, done, pass;
    logic [15:0] err_count, vec_count;

    int          n_tests = 0;
    int          n_fail = 0;
    int          mode = 0;
    logic [3:0]  fk = 4'd0;

    logic [31:0] va [TOTAL];
    logic [31:0] vb [TOTAL];
    int          m_err;
    logic [31:0] m_fa, m_fb, m_fc;

    always #5 clk = ~clk;

    adder_bist #(.WIDTH(32), .NUM_VECTORS(NV), .SEED_A(SA), .SEED_B(SB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .c         (c),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .vec_count (vec_count),
        .fail_a    (fail_a),
        .fail_b    (fail_b),
        .fail_c    (fail_c)
    );

    // Adder under test: 0 good, 1 missing +1, 2 all-ones pair -> 0, 3 bit-8 flip on a[3:0]==fk.
    function automatic logic [31:0] adder(input int m, input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] k);
        logic [31:0] good;
        good = a + b + 32'd1;
        case (m)
            1:       return a + b;
            2:       return (a == 32'hFFFF_FFFF && b == 32'hFFFF_FFFF) ? 32'd0 : good;
            3:       return (a[3:0] == k) ? (good ^ 32'h100) : good;
            default: return good;
        endcase
    endfunction

    always_comb c = adder(mode, op_a, op_b, fk);

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (((s % 2) == 1) ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected vector sequence and run outcome for the current fault mode.
    task automatic build_model();
        logic [31:0] sa, sb, got;
        va[0] = 32'h0;          vb[0] = 32'h0;
        va[1] = 32'hFFFF_FFFF;  vb[1] = 32'h0;
        va[2] = 32'hFFFF_FFFF;  vb[2] = 32'hFFFF_FFFF;
        va[3] = 32'h7FFF_FFFF;  vb[3] = 32'h0;
        sa = SA; sb = SB;
        for (int i = 4; i < TOTAL; i++) begin
            va[i] = sa; vb[i] = sb;
            sa = lfsr_next(sa); sb = lfsr_next(sb);
        end
        m_err = 0; m_fa = 0; m_fb = 0; m_fc = 0;
        for (int i = 0; i < TOTAL; i++) begin
            got = adder(mode, va[i], vb[i], fk);
            if (got != va[i] + vb[i] + 32'd1) begin
                if (m_err == 0) begin m_fa = va[i]; m_fb = vb[i]; m_fc = got; end
                m_err++;
            end
        end
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'(m_err == 0));
        chk({tag, "_err"}, 64'(err_count), 64'(m_err));
        chk({tag, "_vec"}, 64'(vec_count), 64'(TOTAL));
        chk({tag, "_fa"}, 64'(fail_a), 64'(m_fa));
        chk({tag, "_fb"}, 64'(fail_b), 64'(m_fb));
        chk({tag, "_fc"}, 64'(fail_c), 64'(m_fc));
        chk({tag, "_ops"}, {op_a, op_b}, 64'd0);
    endtask

    // One full run with start held for `hold` cycles; checks every cycle.
    task automatic run(input string tag, input int hold);
        build_model();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_busy0"}, 64'(busy), 64'd1);
        chk({tag, "_vec0"}, {op_a, op_b}, {va[0], vb[0]});
        for (int k = 1; k <= TOTAL; k++) begin
            @(negedge clk);
            if (k >= hold) start = 1'b0;
            @(posedge clk); #1;
            if (k < TOTAL) begin
                if ({op_a, op_b} !== {va[k], vb[k]} || busy !== 1'b1 || done !== 1'b0) begin
                    chk({tag, "_stream"}, {op_a, op_b}, {va[k], vb[k]});
                    chk({tag, "_stream_busy"}, 64'({busy, done}), 64'd2);
                end
            end
        end
        n_tests++;
        check_results(tag);
        repeat (3) @(posedge clk);
        #1;
        check_results({tag, "_hold"});
    endtask

    initial begin
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_cnts", 64'({err_count, vec_count}), 64'd0);
        chk("rst_ops", {op_a, op_b}, 64'd0);
        chk("rst_fail", 64'({fail_a, fail_b}), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        mode = 0; run("good", 1);
        mode = 1; run("noinc", 10);
        mode = 2; run("ones", 1);
        run("ones_again", 1);

        // Reset mid-run, then a clean full run.
        mode = 3; fk = 4'($urandom_range(0, 15));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (99) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_pass", 64'(pass), 64'd0);
        chk("mid_cnts", 64'({err_count, vec_count}), 64'd0);
        chk("mid_ops", {op_a, op_b}, 64'd0);
        chk("mid_fail", 64'({fail_a, fail_b}), 64'd0);
        chk("mid_failc", 64'(fail_c), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        run("after_rst", 1);

        for (int r = 0; r < 4; r++) begin
            mode = int'($urandom_range(0, 3));
            fk = 4'($urandom_range(0, 15));
            run("rand", int'($urandom_range(1, 10)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
